// File: rtl/free_list.sv
// Circular free list of physical register tags: up to 4 in-order grants and 4 releases per cycle.
// Grants are combinational from current state; alloc_ready low holds head (all-or-nothing); releases are always accepted.
module free_list #(
    parameter int NUM_PR = 128,
    parameter int NUM_AR = 32,
    parameter int TW     = $clog2(NUM_PR),
    parameter int PW     = TW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_stage4,
    input  logic          alloc_req0,
    input  logic          alloc_req1,
    input  logic          alloc_req2,
    input  logic          alloc_req3,
    output logic          alloc_ready,
    output logic [TW-1:0] alloc_PR0,
    output logic [TW-1:0] alloc_PR1,
    output logic [TW-1:0] alloc_PR2,
    output logic [TW-1:0] alloc_PR3,
    input  logic          retire0_en,
    input  logic          retire1_en,
    input  logic          retire2_en,
    input  logic          retire3_en,
    input  logic [TW-1:0] retire0_old_PR,
    input  logic [TW-1:0] retire1_old_PR,
    input  logic [TW-1:0] retire2_old_PR,
    input  logic [TW-1:0] retire3_old_PR,
    output logic [PW-1:0] free_count
);

    logic [TW-1:0] entry [NUM_PR];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] commit_head;

    logic [2:0]    apre1, apre2, apre3, req_cnt;
    logic [2:0]    roff [4];
    logic [2:0]    rel_cnt;
    logic          ret_en [4];
    logic [TW-1:0] ret_pr [4];
    logic [TW-1:0] head_idx;
    logic [TW-1:0] tail_idx;
    logic          fire;

    assign ret_en[0] = retire0_en;
    assign ret_en[1] = retire1_en;
    assign ret_en[2] = retire2_en;
    assign ret_en[3] = retire3_en;
    assign ret_pr[0] = retire0_old_PR;
    assign ret_pr[1] = retire1_old_PR;
    assign ret_pr[2] = retire2_old_PR;
    assign ret_pr[3] = retire3_old_PR;

    // Prefix counts compact the requesting lanes onto consecutive entries.
    assign apre1   = 3'(alloc_req0);
    assign apre2   = 3'(alloc_req0) + 3'(alloc_req1);
    assign apre3   = apre2 + 3'(alloc_req2);
    assign req_cnt = apre3 + 3'(alloc_req3);

    assign roff[0] = 3'd0;
    assign roff[1] = 3'(retire0_en);
    assign roff[2] = 3'(retire0_en) + 3'(retire1_en);
    assign roff[3] = roff[2] + 3'(retire2_en);
    assign rel_cnt = roff[3] + 3'(retire3_en);

    assign head_idx = head[TW-1:0];
    assign tail_idx = tail[TW-1:0];

    assign free_count  = tail - head;
    assign alloc_ready = (free_count >= PW'(req_cnt));
    assign fire        = alloc_ready & (req_cnt != 3'd0) & ~flush_stage4;

    assign alloc_PR0 = entry[head_idx];
    assign alloc_PR1 = entry[head_idx + TW'(apre1)];
    assign alloc_PR2 = entry[head_idx + TW'(apre2)];
    assign alloc_PR3 = entry[head_idx + TW'(apre3)];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PR; i++) begin
                entry[i] <= (i < NUM_PR - NUM_AR) ? TW'(NUM_AR + i) : '0;
            end
            head        <= '0;
            commit_head <= '0;
            tail        <= PW'(NUM_PR - NUM_AR);
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (ret_en[k]) begin
                    entry[tail_idx + TW'(roff[k])] <= ret_pr[k];
                end
            end
            tail        <= tail + PW'(rel_cnt);
            commit_head <= commit_head + PW'(rel_cnt);
            // Flush rewinds to the committed point including this cycle's releases.
            if (flush_stage4) begin
                head <= commit_head + PW'(rel_cnt);
            end else if (fire) begin
                head <= head + PW'(req_cnt);
            end
        end
    end

    a_no_overfill: assert property (@(posedge clk) disable iff (!rst_n)
        free_count <= PW'(NUM_PR - NUM_AR));

endmodule

// File: tb/tb_free_list.sv
// Directed table-driven bench for free_list plus sequences for drain, reuse, wrap and reset priority.
module tb_free_list;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic [3:0]      req = '0;
    logic [3:0]      ren = '0;
    logic [3:0][6:0] rpr = '0;
    logic            rdy;
    logic [3:0][6:0] pr_o;
    logic [7:0]      fc;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    free_list dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_stage4   (flush),
        .alloc_req0     (req[0]),
        .alloc_req1     (req[1]),
        .alloc_req2     (req[2]),
        .alloc_req3     (req[3]),
        .alloc_ready    (rdy),
        .alloc_PR0      (pr_o[0]),
        .alloc_PR1      (pr_o[1]),
        .alloc_PR2      (pr_o[2]),
        .alloc_PR3      (pr_o[3]),
        .retire0_en     (ren[0]),
        .retire1_en     (ren[1]),
        .retire2_en     (ren[2]),
        .retire3_en     (ren[3]),
        .retire0_old_PR (rpr[0]),
        .retire1_old_PR (rpr[1]),
        .retire2_old_PR (rpr[2]),
        .retire3_old_PR (rpr[3]),
        .free_count     (fc)
    );

    typedef struct {
        bit              rst;
        logic [3:0]      req;
        logic [3:0]      ren;
        logic [3:0][6:0] rpr;
        bit              flush;
        bit              rdy;
        int              pr [4];
        int              fc;
    } vec_t;

    function automatic vec_t mk(bit rs, logic [3:0] rq, logic [3:0] re,
                                int r0, int r1, int r2, int r3, bit fl, bit rd,
                                int p0, int p1, int p2, int p3, int f);
        vec_t v;
        v.rst = rs; v.req = rq; v.ren = re; v.flush = fl; v.rdy = rd; v.fc = f;
        v.rpr[0] = 7'(r0); v.rpr[1] = 7'(r1); v.rpr[2] = 7'(r2); v.rpr[3] = 7'(r3);
        v.pr[0] = p0; v.pr[1] = p1; v.pr[2] = p2; v.pr[3] = p3;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; ren = '0; rpr = '0; flush = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    vec_t vt [14];
    int   fq [$];
    int   mq [$];
    bit   mapped [128];
    int   r, g;

    initial begin
        // Scenario A: reset grants, one-lane and sparse compaction.
        vt[0]  = mk(1, 4'b1111, 4'b0000, 0,0,0,0, 0, 1, 32,33,34,35, 96);
        vt[1]  = mk(0, 4'b0001, 4'b0000, 0,0,0,0, 0, 1, 36, 0, 0, 0, 92);
        vt[2]  = mk(0, 4'b1010, 4'b0000, 0,0,0,0, 0, 1,  0,37, 0,38, 91);
        vt[3]  = mk(0, 4'b0000, 4'b0000, 0,0,0,0, 0, 1,  0, 0, 0, 0, 89);
        // Scenario B: lanes 0 and 2 only.
        vt[4]  = mk(1, 4'b0101, 4'b0000, 0,0,0,0, 0, 1, 32, 0,33, 0, 96);
        vt[5]  = mk(0, 4'b0001, 4'b0000, 0,0,0,0, 0, 1, 34, 0, 0, 0, 94);
        // Scenario C: allocate 8, retire 2, flush on second retire.
        vt[6]  = mk(1, 4'b1111, 4'b0000, 0,0,0,0, 0, 1, 32,33,34,35, 96);
        vt[7]  = mk(0, 4'b1111, 4'b0000, 0,0,0,0, 0, 1, 36,37,38,39, 92);
        vt[8]  = mk(0, 4'b0000, 4'b0001, 3,0,0,0, 0, 1,  0, 0, 0, 0, 88);
        vt[9]  = mk(0, 4'b1111, 4'b0001, 7,0,0,0, 1, 1, 40,41,42,43, 89);
        vt[10] = mk(0, 4'b1111, 4'b0000, 0,0,0,0, 0, 1, 34,35,36,37, 96);
        vt[11] = mk(0, 4'b0000, 4'b0000, 0,0,0,0, 0, 1,  0, 0, 0, 0, 92);
        // Scenario D head: simultaneous 4 grants and 4 releases.
        vt[12] = mk(1, 4'b1111, 4'b1111, 1,2,3,4, 0, 1, 32,33,34,35, 96);
        vt[13] = mk(0, 4'b0000, 4'b0000, 0,0,0,0, 0, 1,  0, 0, 0, 0, 96);

        for (int i = 0; i < 14; i++) begin
            if (vt[i].rst) do_reset();
            req = vt[i].req; ren = vt[i].ren; rpr = vt[i].rpr; flush = vt[i].flush;
            #2;
            chk($sformatf("v%0d ready", i), int'(rdy), int'(vt[i].rdy));
            chk($sformatf("v%0d free_count", i), int'(fc), vt[i].fc);
            for (int k = 0; k < 4; k++) begin
                if (vt[i].req[k]) chk($sformatf("v%0d alloc_PR%0d", i, k), int'(pr_o[k]), vt[i].pr[k]);
            end
            step();
        end
        req = '0; ren = '0; flush = 1'b0;

        // Scenario D tail: released PR 1..4 appear only after entries 4..95 are consumed.
        for (int i = 0; i < 23; i++) begin
            req = 4'b1111;
            #2;
            chk($sformatf("reuse c%0d free_count", i), int'(fc), 96 - 4 * i);
            for (int k = 0; k < 4; k++) chk($sformatf("reuse c%0d PR%0d", i, k), int'(pr_o[k]), 36 + 4 * i + k);
            step();
        end
        #2;
        for (int k = 0; k < 4; k++) chk($sformatf("reuse wrapped PR%0d", k), int'(pr_o[k]), k + 1);
        chk("reuse final free_count", int'(fc), 4);
        step();
        req = '0;

        // Scenario E: drain to 3, blocked request, single release on lane 2.
        do_reset();
        for (int i = 0; i < 23; i++) begin
            req = 4'b1111;
            #2;
            chk($sformatf("drain c%0d PR0", i), int'(pr_o[0]), 32 + 4 * i);
            step();
        end
        req = 4'b0001;
        step();
        req = 4'b1111;
        #2;
        chk("blocked ready", int'(rdy), 0);
        chk("blocked free_count", int'(fc), 3);
        step();
        #2;
        chk("held free_count", int'(fc), 3);
        ren = 4'b0100; rpr[2] = 7'd5;
        #1;
        chk("same-cycle release ready", int'(rdy), 0);
        step();
        ren = '0; rpr = '0;
        #2;
        chk("refilled free_count", int'(fc), 4);
        chk("refilled ready", int'(rdy), 1);
        chk("refilled PR0", int'(pr_o[0]), 125);
        chk("refilled PR1", int'(pr_o[1]), 126);
        chk("refilled PR2", int'(pr_o[2]), 127);
        chk("refilled PR3", int'(pr_o[3]), 5);
        step();
        req = '0;
        #2;
        chk("empty free_count", int'(fc), 0);
        chk("empty ready idle", int'(rdy), 1);
        step();

        // Scenario F: steady 4-wide allocate/release across the index wrap.
        do_reset();
        fq.delete(); mq.delete();
        for (int i = 0; i < 128; i++) begin
            mapped[i] = (i < 32);
            if (i < 32) mq.push_back(i); else fq.push_back(i);
        end
        for (int c = 0; c < 200; c++) begin
            req = 4'b1111; ren = 4'b1111;
            for (int k = 0; k < 4; k++) rpr[k] = 7'(mq[k]);
            #2;
            chk($sformatf("wrap c%0d free_count", c), int'(fc), 96);
            chk($sformatf("wrap c%0d ready", c), int'(rdy), 1);
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("wrap c%0d PR%0d", c, k), int'(pr_o[k]), fq[k]);
                chk($sformatf("wrap c%0d PR%0d not mapped", c, k), int'(mapped[pr_o[k]]), 0);
            end
            for (int k = 0; k < 4; k++) begin
                r = mq.pop_front(); mapped[r] = 1'b0; fq.push_back(r);
            end
            for (int k = 0; k < 4; k++) begin
                g = fq.pop_front(); mapped[g] = 1'b1; mq.push_back(g);
            end
            step();
        end

        // Scenario G: reset wins over flush, allocation and release.
        rst_n = 1'b0; req = 4'b1111; ren = 4'b1111; flush = 1'b1;
        for (int k = 0; k < 4; k++) rpr[k] = 7'(10 + k);
        step();
        rst_n = 1'b1; ren = '0; flush = 1'b0;
        #2;
        chk("reset-priority free_count", int'(fc), 96);
        chk("reset-priority ready", int'(rdy), 1);
        for (int k = 0; k < 4; k++) chk($sformatf("reset-priority PR%0d", k), int'(pr_o[k]), 32 + k);
        step();
        req = '0;
        #2;
        chk("post-reset grant free_count", int'(fc), 92);
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
